// File: rtl/lc3_obj_loader.sv
// rtl/lc3_obj_loader.sv - LC-3 object-file loader: streams origin + body words into memory
module lc3_obj_loader #(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 16,
  parameter int MAX_WORDS = 64,
  localparam int CW       = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] origin,
  output logic [CW-1:0]     word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ORIGIN,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   origin_q, origin_d;
  // Extra top bit flags that the pointer has walked past the last address.
  logic [ADDR_W:0]     ptr_q, ptr_d;
  logic [CW-1:0]       body_cnt_q, body_cnt_d;
  logic [CW-1:0]       word_count_q, word_count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  // Set once the final body word is in the write stage: stop accepting, wait for drain.
  logic                last_q, last_d;

  logic [ADDR_W-1:0]   data_as_addr;
  logic                wr_accept;
  logic                in_ready_c;

  // Origin word is truncated or zero-extended to the address width.
  generate
    if (WIDTH >= ADDR_W) begin : g_trunc
      assign data_as_addr = in_data[ADDR_W-1:0];
    end else begin : g_zext
      assign data_as_addr = {{(ADDR_W - WIDTH){1'b0}}, in_data};
    end
  endgenerate

  assign wr_accept = we_q && mem_ready;

  // Next-state, write stage and counter updates.
  always_comb begin
    state_d      = state_q;
    origin_d     = origin_q;
    ptr_d        = ptr_q;
    body_cnt_d   = body_cnt_q;
    word_count_d = word_count_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_d       = last_q;
    in_ready_c   = 1'b0;

    if (wr_accept) begin
      we_d         = 1'b0;
      word_count_d = word_count_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_ORIGIN;
          word_count_d = '0;
          body_cnt_d   = '0;
          last_d       = 1'b0;
        end
      end
      S_ORIGIN: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          origin_d = data_as_addr;
          ptr_d    = {1'b0, data_as_addr};
          state_d  = in_last ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready_c = !last_q && (!we_q || mem_ready);
        if (in_valid && in_ready_c) begin
          if ((body_cnt_q == CW'(MAX_WORDS)) || ptr_q[ADDR_W]) begin
            state_d = S_ERR;
          end else begin
            we_d       = 1'b1;
            addr_d     = ptr_q[ADDR_W-1:0];
            wdata_d    = in_data;
            ptr_d      = ptr_q + 1'b1;
            body_cnt_d = body_cnt_q + 1'b1;
            if (in_last) begin
              last_d = 1'b1;
            end
          end
        end
        if (last_q && wr_accept) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      origin_q     <= '0;
      ptr_q        <= '0;
      body_cnt_q   <= '0;
      word_count_q <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      origin_q     <= origin_d;
      ptr_q        <= ptr_d;
      body_cnt_q   <= body_cnt_d;
      word_count_q <= word_count_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_q       <= last_d;
    end
  end

  assign in_ready   = in_ready_c;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state_q == S_ORIGIN) || (state_q == S_LOAD);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign origin     = origin_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_lc3_obj_loader.sv
// tb/tb_lc3_obj_loader.sv - scoreboard bench for lc3_obj_loader
module tb_lc3_obj_loader;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 16;
  localparam int MAX_W  = 4;
  localparam int CW     = $clog2(MAX_W + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_ready = 1'b0;
  logic              busy, done, error;
  logic [ADDR_W-1:0] origin;
  logic [CW-1:0]     word_count;

  lc3_obj_loader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .MAX_WORDS(MAX_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .error(error), .origin(origin), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  int          n_cmp = 0;
  int          n_mis = 0;
  wr_t         sb[$];
  int          rdy_mode = 1;   // 0 random, 1 always, 2 stall first write 3 cycles, 3 never
  int          stall_cnt = 0;
  logic [15:0] body_w[0:15];
  bit          pend = 0;
  wr_t         held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Memory-side ready generator.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: mem_ready = ($urandom % 4) != 0;
      1: mem_ready = 1'b1;
      2: if (mem_we && stall_cnt < 3) begin
           mem_ready = 1'b0;
           stall_cnt++;
         end else begin
           mem_ready = 1'b1;
         end
      default: mem_ready = 1'b0;
    endcase
  end

  // Monitor: pops expected writes on each accepted write, checks hold while stalled.
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      pend = 0;
    end else begin
      if (pend) begin
        chk("we_hold", mem_we, 1);
        chk("addr_hold", mem_addr, held.addr);
        chk("data_hold", mem_wdata, held.data);
      end
      if (mem_we && mem_ready) begin
        if (sb.size() == 0) begin
          chk("pending_expected_writes", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
        end
        pend = 0;
      end else if (mem_we) begin
        pend = 1;
        held.addr = mem_addr;
        held.data = mem_wdata;
        if (busy) chk("stall_in_ready", in_ready, 0);
      end else begin
        pend = 0;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input bit last, input int gaps);
    bit hs;
    int t;
    in_valid = 1'b0;
    repeat ($urandom_range(0, gaps)) begin
      @(posedge clk); #1;
    end
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
      if (hs) break;
      t++;
      if (t > 200) begin
        fail_msg("accept_timeout");
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Reference model: writes land at org+i until the body limit or address space runs out;
  // the offending word is still consumed and dropped.
  task automatic run_prog(input logic [15:0] org, input int n, input int gaps);
    int  nsend, nwr, t;
    bit  exp_err;
    wr_t w;
    exp_err = 0;
    nsend   = n + 1;
    nwr     = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= MAX_W || int'(org) + i > 65535) begin
        exp_err = 1;
        nsend   = i + 2;
        break;
      end
      w.addr = org + 16'(i);
      w.data = body_w[i];
      sb.push_back(w);
      nwr++;
    end

    pulse_start();
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_error", error, 0);
    chk("start_count", word_count, 0);
    @(posedge clk); #1;

    for (int j = 0; j < nsend; j++) begin
      send_word((j == 0) ? org : body_w[j-1], j == n, gaps);
    end

    t = 0;
    while (!((done || error) && !mem_we) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) fail_msg("finish_timeout");

    chk("end_done", done, !exp_err);
    chk("end_error", error, exp_err);
    chk("end_count", word_count, nwr);
    chk("end_origin", origin, org);
    chk("end_busy", busy, 0);

    in_valid = 1'b1;
    in_data  = 16'($urandom);
    repeat (2) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_mem_we", mem_we, 0);
    end
    in_valid = 1'b0;
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_load();
    rdy_mode = 3;
    pulse_start();
    send_word(16'h4000, 1'b0, 0);
    send_word(16'hABCD, 1'b0, 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("rst_pre_we", mem_we, 1);
    chk("rst_pre_addr", mem_addr, 16'h4000);
    chk("rst_pre_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_origin", origin, 0);
    chk("rst_count", word_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 0;
    in_valid = 1'b1;
    in_data  = 16'h5555;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [15:0] org;
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_origin", origin, 0);
    chk("reset_count", word_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    rdy_mode = 1;
    body_w[0] = 16'h1261;
    body_w[1] = 16'h16E8;
    run_prog(16'h3000, 2, 0);

    rdy_mode  = 2;
    stall_cnt = 0;
    run_prog(16'h3000, 2, 0);

    rdy_mode = 1;
    run_prog(16'h3000, 0, 0);

    rdy_mode = 0;
    for (int i = 0; i < 5; i++) body_w[i] = 16'($urandom);
    run_prog(16'h1000, 5, 0);

    for (int i = 0; i < 3; i++) body_w[i] = 16'($urandom);
    run_prog(16'hFFFE, 3, 1);

    reset_mid_load();
    body_w[0] = 16'h1261;
    body_w[1] = 16'h16E8;
    run_prog(16'h3000, 2, 1);

    for (int k = 0; k < 40; k++) begin
      rdy_mode = ($urandom % 2 == 0) ? 0 : 1;
      n = $urandom_range(0, 6);
      if ($urandom % 3 == 0) org = 16'hFFFF - 16'($urandom_range(0, 4));
      else                   org = 16'($urandom);
      for (int i = 0; i < 16; i++) body_w[i] = 16'($urandom);
      run_prog(org, n, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/lc3_obj_loader.md
LC3_OBJ_LOADER -- requirements
Module: lc3_obj_loader

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits.
REQ-002 Parameter ADDR_W, default 16: memory address width in bits.
REQ-003 Parameter MAX_WORDS, default 64: maximum number of body words per program (excludes the origin word); CW = $clog2(MAX_WORDS+1).
REQ-004 Clocking SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  single-cycle request to begin loading a program.
REQ-008 in_valid  input  1  object-word stream valid.
REQ-009 in_data  input  WIDTH  object word; the first word of a program is its origin (.ORIG) address, the rest are the body.
REQ-010 in_last  input  1  marks the final word of the program.
REQ-011 in_ready  output  1  loader accepts in_data this cycle.
REQ-012 mem_we  output  1  memory write request, held until accepted.
REQ-013 mem_addr  output  ADDR_W  write address.
REQ-014 mem_wdata  output  WIDTH  write data.
REQ-015 mem_ready  input  1  memory accepts the write this cycle.
REQ-016 busy  output  1  high in ORIGIN or LOAD.
REQ-017 done  output  1  high in DONE.
REQ-018 error  output  1  high in ERR.
REQ-019 origin  output  ADDR_W  captured origin; intended as the CPU start PC.
REQ-020 word_count  output  CW  body words written to memory so far.

Function
REQ-021 An input word SHALL be transferred only on a rising edge where in_valid and in_ready are both high.
REQ-022 FSM states SHALL be IDLE, ORIGIN, LOAD, DONE and ERR.
REQ-023 IDLE/DONE/ERR + start -> ORIGIN; word_count SHALL clear to 0 and error/done SHALL drop on the same edge.
REQ-024 start in ORIGIN or LOAD SHALL be ignored.
REQ-025 In ORIGIN, in_ready=1; the transferred word SHALL load origin (low ADDR_W bits, zero-extended if WIDTH<ADDR_W) and the write pointer; next state LOAD, or DONE if in_last=1 (empty program, word_count=0).
REQ-026 In LOAD, in_ready SHALL equal (!mem_we || mem_ready), i.e. a one-entry registered write stage with no bubble under continuous mem_ready.
REQ-027 Each body-word transfer SHALL, one edge later, present mem_we=1, mem_addr=write pointer, mem_wdata=word; the pointer then increments by 1.
REQ-028 mem_we SHALL remain high with mem_addr/mem_wdata stable until an edge with mem_ready=1.
REQ-029 word_count SHALL increment on each edge where mem_we && mem_ready.
REQ-030 The body word with in_last=1 SHALL move the FSM to a drain condition; DONE SHALL be entered on the edge the final write is accepted; mem_we=0 in DONE.
REQ-031 A body transfer when MAX_WORDS body words have already been transferred SHALL enter ERR; the word SHALL be dropped and no further mem_we raised.
REQ-032 A body transfer whose write address would exceed 2^ADDR_W-1 (pointer wrap) SHALL enter ERR and drop the word; the write at address 2^ADDR_W-1 itself is legal.
REQ-033 On entry to ERR, a pending accepted write SHALL still complete; ERR and DONE SHALL hold in_ready=0.
REQ-034 Input words arriving in IDLE, DONE or ERR SHALL not be accepted (in_ready=0).
REQ-035 Address arithmetic SHALL be unsigned modulo-free: ADDR_W+1-bit compare for wrap detection.

Reset
REQ-036 rst=1 SHALL immediately force state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, origin=0, word_count=0.
REQ-037 rst asserted mid-load SHALL abandon the program without completing any pending write; loading resumes only after a new start.

Verification
REQ-038 start; stream 3000h, 1261h, 16E8h(last), mem_ready=1 -> writes (3000h,1261h),(3001h,16E8h); done=1, origin=3000h, word_count=2.
REQ-039 Same stream with mem_ready low for 3 cycles on first write -> mem_we/addr/data held stable, in_ready=0 throughout, identical final result.
REQ-040 start; single word 3000h with in_last=1 -> DONE, word_count=0, no mem_we.
REQ-041 MAX_WORDS=4; origin plus 5 body words -> 4 writes accepted, ERR on 5th, error=1, word_count=4.
REQ-042 Origin FFFEh plus 3 body words -> writes at FFFEh, FFFFh, then ERR, word_count=2.
REQ-043 rst pulse during LOAD with mem_we pending -> all outputs zero asynchronously; new start and program load correctly.
